regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Round-robin arbiter and sequencer that shares one register-block bus between `N_REQ` requesters, e.g. a CPU port, a DMA engine and a debug port. It sits in front of `testRegBlock`, driving the `memory_32_32` master side: ADDR, WE, RE, DATA_WR and WSTRB out, DATA_RD and READY in. It runs one transaction at a time and holds the bus strobe until READY. A timeout terminates any access the target never acknowledges and returns an error.

## Interface
- `N_REQ`, 2: number of requesters; legal range 2..4.
- `ADDR_W`, 32: bus address width.
- `DATA_W`, 32: bus data width.
- `TIMEOUT`, 16: maximum BUSY cycles before an access is errored; legal range 2..255.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_b`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request; held stable until accepted.
- `req_we`  in  N_REQ  1 = write, 0 = read.
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W].
- `req_wdata`  in  N_REQ*DATA_W  packed write data.
- `req_wstrb`  in  N_REQ*4  packed byte strobes.
- `req_ready`  out  N_REQ  one-hot accept; combinational in IDLE.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse.
- `rsp_rdata`  out  DATA_W  read data, valid with `rsp_valid`.
- `rsp_err`  out  1  timeout flag, valid with `rsp_valid`.
- `bus_addr`  out  ADDR_W  to regs.ADDR.
- `bus_we`  out  1  to regs.WE.
- `bus_re`  out  1  to regs.RE.
- `bus_wdata`  out  DATA_W  to regs.DATA_WR.
- `bus_wstrb`  out  4  to regs.WSTRB.
- `bus_rdata`  in  DATA_W  from regs.DATA_RD.
- `bus_ready`  in  1  from regs.READY.

## Operation
- FSM has three states: IDLE, BUSY and RESP.
- IDLE behaviour:
  - Grant is round-robin: search starts at `last_grant+1` mod N_REQ, and the first set `req_valid` wins.
  - `req_ready[g]` asserts combinationally in the same cycle.
  - On that edge the block latches addr, we, wdata and wstrb into bus registers, records `g`, sets `last_grant=g`, clears the timer and moves to BUSY.
- BUSY behaviour:
  - `bus_re=!we` or `bus_we=we` is held high, and bus_addr, wdata and wstrb are held stable.
  - If `bus_ready` is sampled high, capture `bus_rdata` into `rsp_rdata`, set `rsp_err=0`, go to RESP.
  - Otherwise the timer increments. When the timer reaches TIMEOUT-1 without `bus_ready`, set `rsp_rdata=0`, set `rsp_err=1`, go to RESP.
- RESP behaviour: `rsp_valid[g]=1` for exactly one cycle, strobes are low, then return to IDLE.
- On writes, `rsp_rdata` is don't-care; the implementation drives captured `bus_rdata`.
- Requests arriving while not in IDLE wait; `req_ready` stays 0 outside IDLE.
- The timer is 8 bits and saturates; it never wraps.

## Timing
- Reset values:
  - `last_grant=N_REQ-1`, so requester 0 wins first.
  - State is IDLE.
  - All outputs are 0: `req_ready`, `rsp_valid`, `rsp_rdata`, `rsp_err`, and all bus outputs.
- Latency:
  - Accept at edge 0.
  - Strobe high from cycle 1.
  - With `bus_ready` high in cycle k≥1, `rsp_valid` is high in cycle k+1.
  - IDLE in cycle k+2.
- Throughput: minimum 3 cycles per transaction.
- Timeout: the strobe is high for exactly TIMEOUT cycles, then the error response follows in the next cycle.
- If `bus_ready` arrives in the same cycle the timer hits TIMEOUT-1, success wins (`rsp_err=0`).
- `bus_ready` sampled in IDLE or RESP is ignored.
- Reset asserted mid-transaction:
  - All state and outputs clear immediately (asynchronous).
  - The in-flight access is dropped and no response is issued.
  - The round-robin pointer returns to N_REQ-1.
- Simultaneous `req_valid` from all requesters gives strict rotation 0,1,…,N_REQ-1,0.

## Test plan
- Single write: req0 writes addr 0x0, data 0x12345678, strb 0xF; `bus_ready` returns 1 cycle after the strobe. Required: `bus_we` high 2 cycles, `rsp_valid[0]` pulses, `rsp_err=0`, and REG0 reads back 0x12345678.
- Single read: req1 reads addr 0x8 after writing 0x87654321. Required: `rsp_valid[1]` with `rsp_rdata=0x87654321`.
- Contention: N_REQ=3, all valid continuously for 6 transactions. Required: grant order 0,1,2,0,1,2, one `rsp_valid` per grant, no overlap of strobes.
- Timeout: read to an unmapped address with `bus_ready` tied 0. Required:
  - `bus_re` high exactly 16 cycles.
  - Then `rsp_valid` with `rsp_err=1` and `rsp_rdata=0`.
  - The next request is granted normally.
- Ready at the boundary: `bus_ready` first asserted in the 16th BUSY cycle with rdata 0xAABBCCDD. Required: `rsp_err=0`, `rsp_rdata=0xAABBCCDD`.
- Reset mid-BUSY: drop `rst_b` during the 3rd BUSY cycle. Required:
  - All outputs are 0 in the same cycle.
  - No `rsp_valid` is issued.
  - After release with req1 and req2 valid, req0 is not granted, and req1 is granted first (pointer reset).

Source files
------------

// File: rtl/regbus_arbiter.sv
// Round-robin arbiter that shares one register-block bus between NReq requesters.
// One access at a time; the strobe is held until bus_ready_i or until a timeout errors the access.
module regbus_arbiter #(
  parameter int unsigned NReq    = 2,
  parameter int unsigned AddrW   = 32,
  parameter int unsigned DataW   = 32,
  parameter int unsigned Timeout = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NReq-1:0]       req_valid_i,
  input  logic [NReq-1:0]       req_we_i,
  input  logic [NReq*AddrW-1:0] req_addr_i,
  input  logic [NReq*DataW-1:0] req_wdata_i,
  input  logic [NReq*4-1:0]     req_wstrb_i,
  output logic [NReq-1:0]       req_ready_o,
  output logic [NReq-1:0]       rsp_valid_o,
  output logic [DataW-1:0]      rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [AddrW-1:0]      bus_addr_o,
  output logic                  bus_we_o,
  output logic                  bus_re_o,
  output logic [DataW-1:0]      bus_wdata_o,
  output logic [3:0]            bus_wstrb_o,
  input  logic [DataW-1:0]      bus_rdata_i,
  input  logic                  bus_ready_i
);

  localparam int unsigned IdxW = $clog2(NReq);

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [IdxW-1:0]   gnt_q, gnt_d;
  logic              we_q, we_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [7:0]        timer_q, timer_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [IdxW-1:0]   pick;
  logic              pick_vld;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned i = 1; i <= NReq; i++) begin
      idx  = (32'(last_q) + i) % NReq;
      cand = IdxW'(idx);
      if (!pick_vld && req_valid_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    timer_d     = timer_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    req_ready_o = '0;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          req_ready_o[pick] = 1'b1;
          gnt_d             = pick;
          last_d            = pick;
          we_d              = req_we_i[pick];
          addr_d            = req_addr_i[32'(pick)*AddrW +: AddrW];
          wdata_d           = req_wdata_i[32'(pick)*DataW +: DataW];
          wstrb_d           = req_wstrb_i[32'(pick)*4 +: 4];
          timer_d           = '0;
          state_d           = StBusy;
        end
      end
      StBusy: begin
        // A late acknowledge still beats the timeout in the same cycle.
        if (bus_ready_i) begin
          rdata_d = bus_rdata_i;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timer_q == 8'(Timeout - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StResp;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      last_q  <= IdxW'(NReq - 1);
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      timer_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      timer_q <= timer_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    if (state_q == StResp) rsp_valid_o[gnt_q] = 1'b1;
  end

  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;
  assign bus_wstrb_o = wstrb_q;
  assign bus_we_o    = (state_q == StBusy) && we_q;
  assign bus_re_o    = (state_q == StBusy) && !we_q;

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed bench for regbus_arbiter with three requesters and a 16-cycle timeout.
module tb_regbus_arbiter;

  localparam int unsigned NReq    = 3;
  localparam int unsigned AddrW   = 32;
  localparam int unsigned DataW   = 32;
  localparam int unsigned Timeout = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic [NReq-1:0]       req_valid_i;
  logic [NReq-1:0]       req_we_i;
  logic [NReq*AddrW-1:0] req_addr_i;
  logic [NReq*DataW-1:0] req_wdata_i;
  logic [NReq*4-1:0]     req_wstrb_i;
  logic [NReq-1:0]       req_ready_o;
  logic [NReq-1:0]       rsp_valid_o;
  logic [DataW-1:0]      rsp_rdata_o;
  logic                  rsp_err_o;
  logic [AddrW-1:0]      bus_addr_o;
  logic                  bus_we_o;
  logic                  bus_re_o;
  logic [DataW-1:0]      bus_wdata_o;
  logic [3:0]            bus_wstrb_o;
  logic [DataW-1:0]      bus_rdata_i;
  logic                  bus_ready_i;

  int vectors     = 0;
  int miscompares = 0;

  regbus_arbiter #(
    .NReq   (NReq),
    .AddrW  (AddrW),
    .DataW  (DataW),
    .Timeout(Timeout)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_we_i   (req_we_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_wstrb_i(req_wstrb_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .bus_addr_o (bus_addr_o),
    .bus_we_o   (bus_we_o),
    .bus_re_o   (bus_re_o),
    .bus_wdata_o(bus_wdata_o),
    .bus_wstrb_o(bus_wstrb_o),
    .bus_rdata_i(bus_rdata_i),
    .bus_ready_i(bus_ready_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // One transaction from requester r; bus_ready_i is raised in BUSY cycle delay+1.
  task automatic txn(input int r, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int delay, input logic [31:0] rd_bus,
                     input logic [31:0] exp_rd);
    int n;
    req_valid_i[r]           = 1'b1;
    req_we_i[r]              = we;
    req_addr_i[r*AddrW +: AddrW] = addr;
    req_wdata_i[r*DataW +: DataW] = wdata;
    req_wstrb_i[r*4 +: 4]    = strb;
    #1;
    chk("accept", 64'(req_ready_o), 64'(1 << r));
    tick();
    req_valid_i[r] = 1'b0;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      chk("strobe", 64'({bus_we_o, bus_re_o}), 64'({we, !we}));
      chk("bus_addr", 64'(bus_addr_o), 64'(addr));
      if (we) begin
        chk("bus_wdata", 64'(bus_wdata_o), 64'(wdata));
        chk("bus_wstrb", 64'(bus_wstrb_o), 64'(strb));
      end
      n++;
      if (c == delay + 1) begin
        bus_ready_i = 1'b1;
        bus_rdata_i = rd_bus;
        tick();
        bus_ready_i = 1'b0;
        break;
      end
      tick();
    end
    chk("strobe_len", 64'(n), 64'(delay + 1));
    chk("rsp_valid", 64'(rsp_valid_o), 64'(1 << r));
    chk("rsp_err", 64'(rsp_err_o), 64'(0));
    if (!we) chk("rsp_rdata", 64'(rsp_rdata_o), 64'(exp_rd));
    chk("resp_strobe_off", 64'({bus_we_o, bus_re_o}), 64'(0));
    tick();
    chk("back_idle", 64'(rsp_valid_o), 64'(0));
  endtask

  initial begin
    int n;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_we_i    = '0;
    req_addr_i  = '0;
    req_wdata_i = '0;
    req_wstrb_i = '0;
    bus_rdata_i = '0;
    bus_ready_i = 1'b0;
    #12;
    chk("rst_ctl", 64'({req_ready_o, rsp_valid_o, rsp_err_o, bus_we_o, bus_re_o, bus_wstrb_o}),
        64'(0));
    chk("rst_addr", 64'(bus_addr_o), 64'(0));
    chk("rst_data", 64'({rsp_rdata_o, bus_wdata_o}), 64'(0));
    rst_ni = 1'b1;
    tick();

    // Write then read back REG0; write then read 0x8 from requester 1.
    txn(0, 1'b1, 32'h0, 32'h12345678, 4'hF, 1, 32'h0, 32'h0);
    txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 1, 32'h12345678, 32'h12345678);
    txn(1, 1'b1, 32'h8, 32'h87654321, 4'hF, 0, 32'h0, 32'h0);
    txn(1, 1'b0, 32'h8, 32'h0, 4'h0, 0, 32'h87654321, 32'h87654321);

    // Idle reset pulse returns the pointer so rotation starts at 0.
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    req_we_i    = '0;
    req_addr_i  = {32'h20, 32'h10, 32'h0};
    req_valid_i = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_grant", 64'(req_ready_o), 64'(1 << (k % 3)));
      tick();
      chk("rr_addr", 64'(bus_addr_o), 64'((k % 3) * 16));
      chk("rr_busy_noready", 64'(req_ready_o), 64'(0));
      bus_ready_i = 1'b1;
      tick();
      bus_ready_i = 1'b0;
      chk("rr_rsp", 64'(rsp_valid_o), 64'(1 << (k % 3)));
      chk("rr_strobe_off", 64'({bus_we_o, bus_re_o}), 64'(0));
      tick();
    end
    req_valid_i = '0;
    tick();

    // Timeout: read from requester 2, target never acknowledges.
    bus_rdata_i = 32'hDEADBEEF;
    req_valid_i[2] = 1'b1;
    req_addr_i[2*AddrW +: AddrW] = 32'h100;
    #1;
    chk("to_accept", 64'(req_ready_o), 64'(3'b100));
    tick();
    req_valid_i[2] = 1'b0;
    n = 0;
    while (bus_re_o && n < 40) begin
      n++;
      tick();
    end
    chk("to_strobe_len", 64'(n), 64'(16));
    chk("to_rsp_valid", 64'(rsp_valid_o), 64'(3'b100));
    chk("to_rsp_err", 64'(rsp_err_o), 64'(1));
    chk("to_rsp_rdata", 64'(rsp_rdata_o), 64'(0));
    tick();
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, 32'h55AA55AA, 32'h55AA55AA);

    // Acknowledge lands in the 16th BUSY cycle: success wins.
    txn(1, 1'b0, 32'hC, 32'h0, 4'h0, 15, 32'hAABBCCDD, 32'hAABBCCDD);

    // Reset during the 3rd BUSY cycle.
    req_valid_i[0] = 1'b1;
    req_we_i[0]    = 1'b0;
    req_addr_i[0 +: AddrW] = 32'h18;
    #1;
    chk("mr_accept", 64'(req_ready_o), 64'(3'b001));
    tick();
    req_valid_i[0] = 1'b0;
    tick();
    tick();
    chk("mr_busy3", 64'(bus_re_o), 64'(1));
    rst_ni = 1'b0;
    #1;
    chk("mr_ctl", 64'({req_ready_o, rsp_valid_o, rsp_err_o, bus_we_o, bus_re_o, bus_wstrb_o}),
        64'(0));
    chk("mr_addr", 64'(bus_addr_o), 64'(0));
    chk("mr_data", 64'({rsp_rdata_o, bus_wdata_o}), 64'(0));
    tick();
    chk("mr_no_rsp", 64'(rsp_valid_o), 64'(0));
    req_valid_i = 3'b110;
    rst_ni = 1'b1;
    #1;
    chk("mr_first_grant", 64'(req_ready_o), 64'(3'b010));
    tick();
    req_valid_i[1] = 1'b0;
    chk("mr_busy_no_rsp", 64'(rsp_valid_o), 64'(0));
    bus_ready_i = 1'b1;
    tick();
    bus_ready_i = 1'b0;
    chk("mr_rsp", 64'(rsp_valid_o), 64'(3'b010));
    tick();
    #1;
    chk("mr_next_grant", 64'(req_ready_o), 64'(3'b100));
    req_valid_i = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
